// File: rtl/mby_msh_pkg.sv
// mby_msh_pkg: shared mesh-node widths and memory request types.
package mby_msh_pkg;
    localparam int MSH_NUM_PORTS  = 4;
    localparam int MSH_MEM_ADDR_W = 20;
    localparam int MSH_MEM_DATA_W = 64;
    typedef struct packed {
        logic                      wr;
        logic [MSH_MEM_ADDR_W-1:0] addr;
        logic [MSH_MEM_DATA_W-1:0] data;
    } msh_mem_req_t;
    typedef logic [$clog2(MSH_NUM_PORTS)-1:0] msh_port_idx_t;
endpackage

// File: rtl/mby_msh_mem_req_arb_if.sv
// mby_msh_mem_req_arb_if: per-port request inputs and granted request output of the arbiter.
interface mby_msh_mem_req_arb_if import mby_msh_pkg::*; #(
    parameter int NUM_PORTS = MSH_NUM_PORTS,
    parameter int ADDR_W    = MSH_MEM_ADDR_W,
    parameter int DATA_W    = MSH_MEM_DATA_W
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    logic [NUM_PORTS-1:0]        in_vld;
    logic [NUM_PORTS-1:0]        in_rdy;
    logic [NUM_PORTS-1:0]        in_wr;
    logic [NUM_PORTS*ADDR_W-1:0] in_addr;
    logic [NUM_PORTS*DATA_W-1:0] in_data;
    logic                        out_vld;
    logic                        out_rdy;
    logic                        out_wr;
    logic [ADDR_W-1:0]           out_addr;
    logic [DATA_W-1:0]           out_data;
    logic [PORT_W-1:0]           out_port;
    modport master (
        output in_vld, in_wr, in_addr, in_data, out_rdy,
        input  in_rdy, out_vld, out_wr, out_addr, out_data, out_port
    );
    modport slave (
        input  in_vld, in_wr, in_addr, in_data, out_rdy,
        output in_rdy, out_vld, out_wr, out_addr, out_data, out_port
    );
endinterface

// File: rtl/mby_msh_req_fifo.sv
// mby_msh_req_fifo: small synchronous FIFO (power-of-2 depth) exposing its head entry.
module mby_msh_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign head  = mem_q[rd_q];
    always_comb begin
        do_push = push & !full;
        do_pop  = pop & !empty;
        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = (do_push && wr_q == AW'(i)) ? din : mem_q[i];
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mby_msh_mem_req_arb.sv
// mby_msh_mem_req_arb: per-port request FIFOs, round-robin grant into a registered output stage.
// Grant counters on stat_gnt_cnt exist only when MBY_MSH_MEM_REQ_ARB_STATS_EN is defined.
module mby_msh_mem_req_arb import mby_msh_pkg::*; #(
    parameter int NUM_PORTS  = MSH_NUM_PORTS,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = MSH_MEM_ADDR_W,
    parameter int DATA_W     = MSH_MEM_DATA_W
) (
    input  logic                    mclk,
    input  logic                    rst,
    mby_msh_mem_req_arb_if.slave    bus,
    output logic [NUM_PORTS*16-1:0] stat_gnt_cnt
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int REQ_W  = 1 + ADDR_W + DATA_W;
    logic [NUM_PORTS-1:0] full, empty, push, pop;
    logic [REQ_W-1:0]     head [NUM_PORTS];
    logic                 load, hit, take;
    logic [PORT_W-1:0]    gnt, k;
    logic                 out_vld_q, out_vld_d;
    logic [REQ_W-1:0]     out_req_q, out_req_d;
    logic [PORT_W-1:0]    out_port_q, out_port_d, rr_ptr_q, rr_ptr_d;
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign push[p] = bus.in_vld[p] & bus.in_rdy[p];
        mby_msh_req_fifo #(.W(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk  (mclk),
            .rst  (rst),
            .push (push[p]),
            .pop  (pop[p]),
            .din  ({bus.in_wr[p], bus.in_addr[p*ADDR_W +: ADDR_W], bus.in_data[p*DATA_W +: DATA_W]}),
            .full (full[p]),
            .empty(empty[p]),
            .head (head[p])
        );
    end
    assign bus.in_rdy = rst ? '0 : ~full;
    always_comb begin
        load = !out_vld_q | bus.out_rdy;
        hit  = 1'b0;
        gnt  = '0;
        k    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = PORT_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
            if (!hit && !empty[k]) begin
                hit = 1'b1;
                gnt = k;
            end
        end
        take       = load & hit;
        pop        = take ? (NUM_PORTS'(1) << gnt) : '0;
        out_vld_d  = load ? hit : out_vld_q;
        out_req_d  = take ? head[gnt] : out_req_q;
        out_port_d = take ? gnt : out_port_q;
        rr_ptr_d   = take ? PORT_W'((int'(gnt) + 1) % NUM_PORTS) : rr_ptr_q;
    end
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_req_q  <= '0;
            out_port_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_req_q  <= out_req_d;
            out_port_q <= out_port_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end
    assign bus.out_vld = out_vld_q;
    assign {bus.out_wr, bus.out_addr, bus.out_data} = out_req_q;
    assign bus.out_port = out_port_q;
`ifdef MBY_MSH_MEM_REQ_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_PORTS];
    logic [15:0] cnt_d [NUM_PORTS];
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            cnt_d[i] = (take && gnt == PORT_W'(i) && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
    end
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
        else cnt_q <= cnt_d;
    end
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stat
        assign stat_gnt_cnt[p*16 +: 16] = cnt_q[p];
    end
`else
    assign stat_gnt_cnt = '0;
`endif
endmodule

// File: tb/tb_mby_msh_mem_req_arb.sv
// tb_mby_msh_mem_req_arb: directed vectors covering reset, latency, round robin, backpressure, mid-flight reset, stats.
module tb_mby_msh_mem_req_arb;
    import mby_msh_pkg::*;
    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic [63:0] stat;
    int          n_chk = 0;
    int          n_fail = 0;
    always #5 mclk = ~mclk;
    mby_msh_mem_req_arb_if bus ();
    mby_msh_mem_req_arb dut (
        .mclk        (mclk),
        .rst         (rst),
        .bus         (bus),
        .stat_gnt_cnt(stat)
    );
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    task automatic step();
        @(posedge mclk);
        #1;
    endtask
    task automatic set_req(input int p, input logic wr, input logic [19:0] a, input logic [63:0] d);
        bus.in_wr[p]              = wr;
        bus.in_addr[p*20 +: 20]   = a;
        bus.in_data[p*64 +: 64]   = d;
    endtask
    task automatic check_out(input string tag, input int port, input logic wr, input logic [19:0] a, input logic [63:0] d);
        check({tag, "_vld"},  64'(bus.out_vld), 64'd1);
        check({tag, "_port"}, 64'(bus.out_port), 64'(port));
        check({tag, "_wr"},   64'(bus.out_wr), 64'(wr));
        check({tag, "_addr"}, 64'(bus.out_addr), 64'(a));
        check({tag, "_data"}, bus.out_data, d);
    endtask
    initial begin
        bus.in_vld  = 4'hF;
        bus.in_wr   = '0;
        bus.in_addr = '0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_in_rdy", 64'(bus.in_rdy), 64'h0);
            check("rst_out_vld", 64'(bus.out_vld), 64'h0);
        end
        check("rst_out_addr", 64'(bus.out_addr), 64'h0);
        check("rst_out_data", bus.out_data, 64'h0);
        bus.in_vld = '0;
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 64'(bus.in_rdy), 64'hF);
        step();
        check("idle_out_vld", 64'(bus.out_vld), 64'h0);
        // single write on port 2, then a read on port 3 which leaves rr_ptr at 0
        set_req(2, 1'b1, 20'h00ABC, 64'hDEAD_BEEF);
        bus.in_vld  = 4'b0100;
        bus.out_rdy = 1'b1;
        step();
        bus.in_vld = '0;
        check("single_lat", 64'(bus.out_vld), 64'h0);
        step();
        check_out("single2", 2, 1'b1, 20'h00ABC, 64'hDEAD_BEEF);
        step();
        check("single2_drop", 64'(bus.out_vld), 64'h0);
        set_req(3, 1'b0, 20'h12345, 64'h0);
        bus.in_vld = 4'b1000;
        step();
        bus.in_vld = '0;
        step();
        check_out("single3", 3, 1'b0, 20'h12345, 64'h0);
        step();
        check("single3_drop", 64'(bus.out_vld), 64'h0);
        bus.out_rdy = 1'b0;
        for (int e = 0; e < 2; e++) begin
            for (int p = 0; p < 4; p++) set_req(p, 1'b0, 20'(p*16 + e), 64'(p*256 + e));
            bus.in_vld = 4'hF;
            step();
        end
        bus.in_vld = '0;
        check("rr_in_rdy", 64'(bus.in_rdy), 64'h1);
        check_out("rr0", 0, 1'b0, 20'h0, 64'h0);
        bus.out_rdy = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step();
            check_out("rr", i % 4, 1'b0, 20'((i % 4)*16 + i/4), 64'((i % 4)*256 + i/4));
        end
        step();
        check("rr_drop", 64'(bus.out_vld), 64'h0);
        // port 1 fills output register plus FIFO; the fourth push must be refused
        bus.out_rdy = 1'b0;
        bus.in_vld  = 4'b0010;
        for (int e = 0; e < 4; e++) begin
            set_req(1, 1'b1, 20'hB0000 + 20'(e), 64'hB0 + 64'(e));
            step();
        end
        bus.in_vld = '0;
        check_out("bp_hold", 1, 1'b1, 20'hB0000, 64'hB0);
        check("bp_in_rdy", 64'(bus.in_rdy), 64'hD);
        step();
        step();
        check_out("bp_stable", 1, 1'b1, 20'hB0000, 64'hB0);
        bus.out_rdy = 1'b1;
        step();
        check_out("bp_g1", 1, 1'b1, 20'hB0001, 64'hB1);
        step();
        check_out("bp_g2", 1, 1'b1, 20'hB0002, 64'hB2);
        step();
        check("bp_drop", 64'(bus.out_vld), 64'h0);
        bus.out_rdy = 1'b0;
        bus.in_vld  = 4'b0111;
        for (int e = 0; e < 2; e++) begin
            for (int p = 0; p < 3; p++) set_req(p, 1'b0, 20'hC0000 + 20'(p*16 + e), 64'(e));
            step();
        end
        bus.in_vld = '0;
        check_out("mid_pre", 2, 1'b0, 20'hC0020, 64'h0);
        #2 rst = 1'b1;
        #1;
        check("mid_async_vld", 64'(bus.out_vld), 64'h0);
        check("mid_in_rdy", 64'(bus.in_rdy), 64'h0);
        step();
        rst = 1'b0;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_quiet", 64'(bus.out_vld), 64'h0);
        end
        set_req(0, 1'b1, 20'h0FACE, 64'h1234);
        bus.in_vld = 4'b0001;
        step();
        bus.in_vld = '0;
        step();
        check_out("post_rst", 0, 1'b1, 20'h0FACE, 64'h1234);
        step();
`ifdef MBY_MSH_MEM_REQ_ARB_STATS_EN
        check("stat_one", stat, 64'h1);
        bus.in_vld = 4'b0001;
        repeat (65540) step();
        bus.in_vld = '0;
        step();
        step();
        check("stat_sat", 64'(stat[15:0]), 64'hFFFF);
        check("stat_others", 64'(stat[63:16]), 64'h0);
`else
        check("stat_off", stat, 64'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mby_msh_mem_req_arb.md
Name: mby_msh_mem_req_arb

Overview:
- Request arbiter directly upstream of mby_msh_mem_dp inside a mesh node.
- Collects memory read/write requests from NUM_PORTS mesh inputs (N, S, E, W by default) into small per-port FIFOs.
- Grants one request per cycle in round-robin order and presents it through a registered valid/ready output stage that mby_msh_mem_dp consumes.

Parameters:
- NUM_PORTS, 4: number of requesting mesh ports.
- FIFO_DEPTH, 2: entries per input FIFO; must be a power of 2 and at least 2.
- ADDR_W, 20: request address width.
- DATA_W, 64: write data width.
- PORT_W, $clog2(NUM_PORTS): width of the port index. This is a derived localparam, not overridable.

Ports:
- mclk  in  1  mesh clock.
- rst  in  1  asynchronous reset, active-high.
- in_vld  in  NUM_PORTS  per-port request valid.
- in_rdy  out  NUM_PORTS  per-port ready; a request is accepted when in_vld & in_rdy.
- in_wr  in  NUM_PORTS  per-port opcode: 1 = write, 0 = read.
- in_addr  in  NUM_PORTS*ADDR_W  flattened addresses; port p occupies slice [p*ADDR_W +: ADDR_W].
- in_data  in  NUM_PORTS*DATA_W  flattened write data; ignored for reads.
- out_vld  out  1  granted request valid toward mby_msh_mem_dp.
- out_rdy  in  1  mby_msh_mem_dp ready.
- out_wr  out  1  granted opcode.
- out_addr  out  ADDR_W  granted address.
- out_data  out  DATA_W  granted data.
- out_port  out  PORT_W  index of the granted source port.
- stat_gnt_cnt  out  NUM_PORTS*16  per-port grant counters (see Optional Feature).

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All FIFOs empty; rr_ptr = 0.
  - out_vld = 0; out_wr, out_addr, out_data and out_port = 0.
  - stat_gnt_cnt = 0.
  - in_rdy is forced to 0 while rst is high and returns to all-ones the first cycle after deassert.
- in_rdy[p] = !full[p], driven combinationally from the registered FIFO count. There is no dependence on in_vld or out_rdy.
- FIFO push occurs on in_vld[p] & in_rdy[p]. A simultaneous push and pop on a non-full FIFO leaves the count unchanged. A full FIFO cannot push. Pointers wrap modulo FIFO_DEPTH.
- Output stage: a single register. load = !out_vld | out_rdy.
- Arbitration on a load cycle:
  - Search the non-empty FIFOs starting at rr_ptr, ascending, wrapping at NUM_PORTS.
  - The first hit g is popped and its head is registered to the outputs.
  - out_vld is set to 1 and out_port is set to g.
  - rr_ptr becomes (g+1) mod NUM_PORTS.
- If no FIFO is non-empty on a load cycle: out_vld goes to 0 and rr_ptr is unchanged.
- Stall (out_vld & !out_rdy): all out_* signals hold stable, no pop occurs, and rr_ptr is held.
- Latency: a request accepted at edge t appears with out_vld=1 after edge t+1 (2 cycles input-to-output) when the output is free.
- Throughput: 1 request per cycle with out_rdy held high.
- Fairness: with all ports continuously non-empty, grants rotate 0,1,2,3,0,… Each port waits at most NUM_PORTS-1 grants between its own grants.
- Ordering: strictly in order within a port. There is no ordering guarantee across ports.
- Reset mid-operation: all in-flight FIFO entries and the output register are discarded. No partial output is ever presented.

Optional Feature:
- Macro: MBY_MSH_MEM_REQ_ARB_STATS_EN.
- Defined: one 16-bit counter per port increments on each grant to that port and saturates at 16'hFFFF. The counters are driven on stat_gnt_cnt and cleared only by rst.
- Undefined: no counters are instantiated and stat_gnt_cnt is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package mby_msh_pkg gets:
  - localparams MSH_NUM_PORTS, MSH_MEM_ADDR_W and MSH_MEM_DATA_W;
  - typedef msh_mem_req_t, a struct of wr, addr and data;
  - typedef msh_port_idx_t.
- One natural sub-module: mby_msh_req_fifo, a parameterised sync FIFO with push/pop/full/empty/head outputs, instantiated NUM_PORTS times.
- The round-robin search stays inline.

Test Plan:
- Reset: hold rst for 3 cycles with in_vld=4'hF → in_rdy=0 and out_vld=0 throughout. in_rdy=4'hF the first cycle after deassert.
- Single request: port 2 write, addr 20'h00ABC, data 64'hDEAD_BEEF, out_rdy=1 → out_vld high 2 cycles after acceptance with out_port=2, out_wr=1 and matching addr/data. Then out_vld drops.
- Round robin: preload 2 reads into each of ports 0..3, then out_rdy=1 → out_port sequence 0,1,2,3,0,1,2,3 on 8 consecutive cycles.
- Backpressure: out_rdy=0 with port 1 pushing 3 requests → out_vld held with payload stable, 2 entries in the FIFO plus 1 in the output register, in_rdy[1]=0. Raise out_rdy → 3 grants in order on consecutive cycles.
- Mid-flight reset: pulse rst while 3 ports are non-empty and out_vld=1 → out_vld=0 immediately (async), and nothing is emitted after release until new pushes.
- Stats (macro defined): 70000 grants to port 0 → stat_gnt_cnt[15:0]=16'hFFFF. Macro undefined → stat_gnt_cnt=0.
